// File: rtl/sar_seq_pkg.sv
// Shared state encoding and width helper for the SAR conversion scheduler.
package sar_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        TRIAL  = 2'd2,
        HOLD   = 2'd3
    } state_e;

    // Index width for a count of n items, never below one bit.
    function automatic int unsigned cw_of(input int unsigned n);
        int unsigned w;
        w = 1;
        if (n > 1) w = int'($clog2(n));
        return w;
    endfunction

endpackage

// File: rtl/sar_seq_ctrl_if.sv
// Requester, analog-side and result signals of the SAR scheduler.
// SAR_SEQ_OVR_EN adds the sticky overwrite flag OVR.
interface sar_seq_ctrl_if
    import sar_seq_pkg::*;
#(
    parameter int unsigned NBITS = 4,
    parameter int unsigned NCH   = 2
);
    localparam int unsigned CW = cw_of(NCH);

    logic [NCH-1:0]   REQ;
    logic [NCH-1:0]   GNT;
    logic [CW-1:0]    CHSEL;
    logic             SARRST;
    logic [NBITS-1:0] DACEN;
    logic             VCOMP;
    logic             BUSY;
    logic             RES_VALID;
    logic             RES_READY;
    logic [NBITS-1:0] RES_DATA;
    logic [CW-1:0]    RES_CH;
`ifdef SAR_SEQ_OVR_EN
    logic             OVR;

    modport master (
        input  REQ, VCOMP, RES_READY,
        output GNT, CHSEL, SARRST, DACEN, BUSY, RES_VALID, RES_DATA, RES_CH, OVR
    );
    modport slave (
        output REQ, VCOMP, RES_READY,
        input  GNT, CHSEL, SARRST, DACEN, BUSY, RES_VALID, RES_DATA, RES_CH, OVR
    );
`else
    modport master (
        input  REQ, VCOMP, RES_READY,
        output GNT, CHSEL, SARRST, DACEN, BUSY, RES_VALID, RES_DATA, RES_CH
    );
    modport slave (
        output REQ, VCOMP, RES_READY,
        input  GNT, CHSEL, SARRST, DACEN, BUSY, RES_VALID, RES_DATA, RES_CH
    );
`endif

endinterface

// File: rtl/sar_seq_ctrl_rr_arbiter.sv
// Round-robin channel picker: first requester at or after the pointer wins.
module rr_arbiter
    import sar_seq_pkg::*;
#(
    parameter  int unsigned NCH = 2,
    localparam int unsigned CW  = cw_of(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [CW-1:0]  ptr,
    output logic [NCH-1:0] gnt_c,
    output logic [CW-1:0]  idx_c,
    output logic           found_c
);

    logic [CW-1:0] cand;

    always_comb begin
        gnt_c   = '0;
        idx_c   = '0;
        found_c = 1'b0;
        cand    = '0;
        for (int unsigned off = 0; off < NCH; off++) begin
            cand = CW'((32'(ptr) + off) % NCH);
            if (!found_c && req[cand]) begin
                found_c     = 1'b1;
                idx_c       = cand;
                gnt_c[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sar_seq_ctrl.sv
// Multi-channel SAR conversion scheduler: arbitration, sample/trial sequencing, result slot.
// SAR_SEQ_OVR_EN: no HOLD stall; new results overwrite the slot and set sticky OVR.
module sar_seq_ctrl
    import sar_seq_pkg::*;
#(
    parameter int unsigned NBITS      = 4,
    parameter int unsigned NCH        = 2,
    parameter int unsigned SAMPLE_CYC = 1
) (
    input logic            CLK,
    input logic            RESET,
    sar_seq_ctrl_if.master bus
);

    localparam int unsigned CW = cw_of(NCH);
    localparam int unsigned SW = cw_of(SAMPLE_CYC);
    localparam int unsigned BW = cw_of(NBITS);

    state_e           state_q, state_d;
    logic [SW-1:0]    samp_q, samp_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [NBITS-1:0] code_q, code_d, code_fin;
    logic [CW-1:0]    chsel_q, chsel_d;
    logic [CW-1:0]    ptr_q, ptr_d;
    logic [NCH-1:0]   gnt_q, gnt_d;
    logic             sarrst_q, sarrst_d;
    logic [NBITS-1:0] dacen_q, dacen_d;
    logic             busy_q, busy_d;
    logic             res_valid_q, res_valid_d;
    logic [NBITS-1:0] res_data_q, res_data_d;
    logic [CW-1:0]    res_ch_q, res_ch_d;
    logic             arb_take;
`ifdef SAR_SEQ_OVR_EN
    logic             ovr_q, ovr_d;
`endif

    logic [NCH-1:0] arb_gnt_c;
    logic [CW-1:0]  arb_idx_c;
    logic           arb_found_c;

    rr_arbiter #(.NCH(NCH)) u_arb (
        .req     (bus.REQ),
        .ptr     (ptr_q),
        .gnt_c   (arb_gnt_c),
        .idx_c   (arb_idx_c),
        .found_c (arb_found_c)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            samp_q      <= '0;
            bit_q       <= '0;
            code_q      <= '0;
            chsel_q     <= '0;
            ptr_q       <= '0;
            gnt_q       <= '0;
            sarrst_q    <= 1'b0;
            dacen_q     <= '0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_ch_q    <= '0;
`ifdef SAR_SEQ_OVR_EN
            ovr_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            samp_q      <= samp_d;
            bit_q       <= bit_d;
            code_q      <= code_d;
            chsel_q     <= chsel_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            sarrst_q    <= sarrst_d;
            dacen_q     <= dacen_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_ch_q    <= res_ch_d;
`ifdef SAR_SEQ_OVR_EN
            ovr_q       <= ovr_d;
`endif
        end
    end

    // Next-state and next registered outputs.
    always_comb begin
        state_d         = state_q;
        samp_d          = samp_q;
        bit_d           = bit_q;
        code_d          = code_q;
        chsel_d         = chsel_q;
        ptr_d           = ptr_q;
        gnt_d           = '0;
        sarrst_d        = 1'b0;
        dacen_d         = '0;
        res_valid_d     = res_valid_q & ~bus.RES_READY;
        res_data_d      = res_data_q;
        res_ch_d        = res_ch_q;
        arb_take        = 1'b0;
        code_fin        = code_q;
        code_fin[bit_q] = bus.VCOMP;
`ifdef SAR_SEQ_OVR_EN
        ovr_d           = ovr_q & ~(res_valid_q & bus.RES_READY);
`endif

        case (state_q)
            IDLE: arb_take = 1'b1;
            SAMPLE: begin
                if (samp_q == SW'(SAMPLE_CYC - 1)) begin
                    state_d = TRIAL;
                    bit_d   = BW'(NBITS - 1);
                    dacen_d = NBITS'(1) << (NBITS - 1);
                end else begin
                    samp_d   = samp_q + SW'(1);
                    sarrst_d = 1'b1;
                end
            end
            TRIAL: begin
                code_d = code_fin;
                if (bit_q != '0) begin
                    bit_d   = bit_q - BW'(1);
                    dacen_d = code_fin | (NBITS'(1) << bit_d);
                end else begin
`ifdef SAR_SEQ_OVR_EN
                    res_valid_d = 1'b1;
                    res_data_d  = code_fin;
                    res_ch_d    = chsel_q;
                    arb_take    = 1'b1;
                    if (res_valid_q && !bus.RES_READY) ovr_d = 1'b1;
`else
                    if (!res_valid_q || bus.RES_READY) begin
                        res_valid_d = 1'b1;
                        res_data_d  = code_fin;
                        res_ch_d    = chsel_q;
                        arb_take    = 1'b1;
                    end else begin
                        state_d = HOLD;
                    end
`endif
                end
            end
`ifndef SAR_SEQ_OVR_EN
            // Finished code waits here until the consumer frees the slot.
            HOLD: begin
                if (bus.RES_READY) begin
                    res_valid_d = 1'b1;
                    res_data_d  = code_q;
                    res_ch_d    = chsel_q;
                    arb_take    = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (arb_take) begin
            state_d = IDLE;
            if (arb_found_c) begin
                state_d  = SAMPLE;
                gnt_d    = arb_gnt_c;
                chsel_d  = arb_idx_c;
                ptr_d    = CW'((32'(arb_idx_c) + 32'd1) % NCH);
                samp_d   = '0;
                code_d   = '0;
                sarrst_d = 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

    assign bus.GNT       = gnt_q;
    assign bus.CHSEL     = chsel_q;
    assign bus.SARRST    = sarrst_q;
    assign bus.DACEN     = dacen_q;
    assign bus.BUSY      = busy_q;
    assign bus.RES_VALID = res_valid_q;
    assign bus.RES_DATA  = res_data_q;
    assign bus.RES_CH    = res_ch_q;
`ifdef SAR_SEQ_OVR_EN
    assign bus.OVR       = ovr_q;
`endif

endmodule

// File: tb/tb_sar_seq_ctrl.sv
// Directed bench for sar_seq_ctrl with a behavioural comparator and grant/result scoreboards.
// Follows SAR_SEQ_OVR_EN for the stalled-consumer scenario.
module tb_sar_seq_ctrl;
    localparam int unsigned NBITS      = 4;
    localparam int unsigned NCH        = 2;
    localparam int unsigned SAMPLE_CYC = 1;

    typedef struct packed {
        logic [0:0]       ch;
        logic [NBITS-1:0] data;
    } res_t;

    logic CLK = 1'b0;
    logic RESET;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   g_cyc [3];
    logic [NBITS-1:0] vin [NCH];
    res_t             exp_res [$];
    logic [NCH-1:0]   exp_gnt [$];

    sar_seq_ctrl_if #(.NBITS(NBITS), .NCH(NCH)) bus ();

    sar_seq_ctrl #(.NBITS(NBITS), .NCH(NCH), .SAMPLE_CYC(SAMPLE_CYC)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Ideal comparator against the selected channel's input level.
    always_comb bus.VCOMP = (vin[bus.CHSEL] >= bus.DACEN);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic wait_gnt(input string tag);
        int n = 0;
        do begin tick(); n++; end while (bus.GNT == '0 && n < 40);
        chk(tag, 32'(bus.GNT != '0), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin tick(); n++; end while (bus.BUSY && n < 60);
        chk(tag, 32'(bus.BUSY), 32'd0);
        tick();
        tick();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"}, 32'(bus.GNT), 0);
        chk({tag, "_chsel"}, 32'(bus.CHSEL), 0);
        chk({tag, "_sarrst"}, 32'(bus.SARRST), 0);
        chk({tag, "_dacen"}, 32'(bus.DACEN), 0);
        chk({tag, "_busy"}, 32'(bus.BUSY), 0);
        chk({tag, "_valid"}, 32'(bus.RES_VALID), 0);
        chk({tag, "_data"}, 32'(bus.RES_DATA), 0);
        chk({tag, "_resch"}, 32'(bus.RES_CH), 0);
`ifdef SAR_SEQ_OVR_EN
        chk({tag, "_ovr"}, 32'(bus.OVR), 0);
`endif
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        bus.REQ = '0;
        bus.RES_READY = 1'b0;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    // Accepted results are popped from the scoreboard at the accepting edge.
    always @(posedge CLK) begin
        res_t e;
        if (!RESET && bus.RES_VALID && bus.RES_READY) begin
            chk("res_expected", 32'(exp_res.size() != 0), 32'd1);
            if (exp_res.size() != 0) begin
                e = exp_res.pop_front();
                chk("res_data", 32'(bus.RES_DATA), 32'(e.data));
                chk("res_ch", 32'(bus.RES_CH), 32'(e.ch));
            end
        end
    end

    always @(negedge CLK) begin
        if (!RESET && bus.GNT != '0) begin
            chk("gnt_expected", 32'(exp_gnt.size() != 0), 32'd1);
            if (exp_gnt.size() != 0) chk("gnt_order", 32'(bus.GNT), 32'(exp_gnt.pop_front()));
        end
    end

    initial begin
        vin[0] = '0;
        vin[1] = '0;
        do_reset();
        chk_zero("rst");

        // Single conversion, request dropped right after grant.
        vin[0] = 4'b1011;
        bus.RES_READY = 1'b1;
        exp_gnt.push_back(2'b01);
        exp_res.push_back('{ch: 1'b0, data: 4'b1011});
        bus.REQ = 2'b01;
        tick();
        chk("t1_gnt", 32'(bus.GNT), 32'b01);
        chk("t1_sarrst", 32'(bus.SARRST), 1);
        chk("t1_busy", 32'(bus.BUSY), 1);
        chk("t1_dac_s", 32'(bus.DACEN), 0);
        bus.REQ = 2'b00;
        tick(); chk("t1_dac3", 32'(bus.DACEN), 32'b1000);
        chk("t1_sarrst_t", 32'(bus.SARRST), 0);
        tick(); chk("t1_dac2", 32'(bus.DACEN), 32'b1100);
        tick(); chk("t1_dac1", 32'(bus.DACEN), 32'b1010);
        tick(); chk("t1_dac0", 32'(bus.DACEN), 32'b1011);
        chk("t1_novalid", 32'(bus.RES_VALID), 0);
        tick();
        chk("t1_valid", 32'(bus.RES_VALID), 1);
        chk("t1_data", 32'(bus.RES_DATA), 32'b1011);
        chk("t1_ch", 32'(bus.RES_CH), 0);
        chk("t1_idle", 32'(bus.BUSY), 0);
        tick();
        chk("t1_taken", 32'(bus.RES_VALID), 0);

        // Back-to-back alternating grants with both channels requesting.
        do_reset();
        vin[0] = 4'b0101;
        vin[1] = 4'b1110;
        bus.RES_READY = 1'b1;
        exp_gnt.push_back(2'b01); exp_gnt.push_back(2'b10); exp_gnt.push_back(2'b01);
        exp_res.push_back('{ch: 1'b0, data: 4'b0101});
        exp_res.push_back('{ch: 1'b1, data: 4'b1110});
        exp_res.push_back('{ch: 1'b0, data: 4'b0101});
        bus.REQ = 2'b11;
        for (int g = 0; g < 3; g++) begin
            wait_gnt("t2_gnt_seen");
            g_cyc[g] = cyc;
            if (g > 0) chk("t2_spacing", 32'(g_cyc[g] - g_cyc[g-1]), 32'(SAMPLE_CYC + NBITS));
        end
        bus.REQ = 2'b00;
        wait_idle("t2_done");

        // Consumer stalls while the second conversion finishes.
        do_reset();
        vin[0] = 4'b0011;
        vin[1] = 4'b1100;
        bus.RES_READY = 1'b1;
        exp_gnt.push_back(2'b01); exp_gnt.push_back(2'b10); exp_gnt.push_back(2'b01);
`ifdef SAR_SEQ_OVR_EN
        exp_res.push_back('{ch: 1'b1, data: 4'b1100});
`else
        exp_res.push_back('{ch: 1'b0, data: 4'b0011});
        exp_res.push_back('{ch: 1'b1, data: 4'b1100});
`endif
        exp_res.push_back('{ch: 1'b0, data: 4'b0011});
        bus.REQ = 2'b11;
        wait_gnt("t3_gnt1");
        bus.RES_READY = 1'b0;
        wait_gnt("t3_gnt2");
        repeat (5) tick();
`ifdef SAR_SEQ_OVR_EN
        chk("t3_ovr", 32'(bus.OVR), 1);
        chk("t3_gnt3", 32'(bus.GNT), 32'b01);
        chk("t3_ow_data", 32'(bus.RES_DATA), 32'b1100);
        chk("t3_ow_ch", 32'(bus.RES_CH), 1);
        chk("t3_valid", 32'(bus.RES_VALID), 1);
        bus.RES_READY = 1'b1;
        bus.REQ = 2'b00;
        tick();
        chk("t3_ovr_clr", 32'(bus.OVR), 0);
`else
        chk("t3_busy", 32'(bus.BUSY), 1);
        chk("t3_nognt", 32'(bus.GNT), 0);
        chk("t3_dacen", 32'(bus.DACEN), 0);
        chk("t3_sarrst", 32'(bus.SARRST), 0);
        chk("t3_chsel", 32'(bus.CHSEL), 1);
        chk("t3_old_data", 32'(bus.RES_DATA), 32'b0011);
        chk("t3_old_ch", 32'(bus.RES_CH), 0);
        repeat (3) tick();
        chk("t3_still_busy", 32'(bus.BUSY), 1);
        chk("t3_still_nognt", 32'(bus.GNT), 0);
        bus.RES_READY = 1'b1;
        tick();
        chk("t3_gnt3", 32'(bus.GNT), 32'b01);
        chk("t3_new_data", 32'(bus.RES_DATA), 32'b1100);
        chk("t3_new_ch", 32'(bus.RES_CH), 1);
        chk("t3_valid", 32'(bus.RES_VALID), 1);
        bus.REQ = 2'b00;
`endif
        wait_idle("t3_done");

        // Reset in the middle of a conversion clears state and the RR pointer.
        vin[0] = 4'b0110;
        vin[1] = 4'b1001;
        exp_gnt.push_back(2'b01);
        bus.REQ = 2'b01;
        wait_gnt("t4_gnt");
        bus.REQ = 2'b00;
        tick();
        tick();
        chk("t4_trial2", 32'(bus.DACEN), 32'b0100);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk_zero("t4_rst");
        exp_gnt.push_back(2'b01);
        exp_res.push_back('{ch: 1'b0, data: 4'b0110});
        bus.REQ = 2'b11;
        wait_gnt("t4_gnt_ptr0");
        chk("t4_ptr0", 32'(bus.GNT), 32'b01);
        bus.REQ = 2'b00;
        wait_idle("t4_done_a");
        exp_gnt.push_back(2'b10);
        exp_res.push_back('{ch: 1'b1, data: 4'b1001});
        bus.REQ = 2'b10;
        wait_gnt("t4_gnt_ch1");
        chk("t4_ch1", 32'(bus.GNT), 32'b10);
        bus.REQ = 2'b00;
        wait_idle("t4_done_b");

        // Extreme codes.
        vin[0] = 4'b0000;
        vin[1] = 4'b1111;
        exp_gnt.push_back(2'b01); exp_gnt.push_back(2'b10);
        exp_res.push_back('{ch: 1'b0, data: 4'b0000});
        exp_res.push_back('{ch: 1'b1, data: 4'b1111});
        bus.REQ = 2'b11;
        wait_gnt("t5_gnt1");
        wait_gnt("t5_gnt2");
        bus.REQ = 2'b00;
        wait_idle("t5_done");

        chk("res_q_empty", 32'(exp_res.size()), 0);
        chk("gnt_q_empty", 32'(exp_gnt.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
